// File: rtl/inv_mix_cols_dec.sv
// AES InvMixColumns over a 128-bit state, one column per clock with valid/ready on both sides.
// Build option INV_MIX_PARALLEL_EN: four column datapaths finish the whole state in one BUSY cycle.
module inv_mix_cols_dec #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_o,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for an input state, in_ready high
  // BUSY  | writing result columns from the captured input
  // DONE  | result held on state_o, out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam int CW = $clog2(NCOL);
  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

  fsm_t           fsm;
  logic [CW-1:0]  col_idx;
  logic [127:0]   in_reg;
  logic [127:0]   res_reg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 9, 11, 13 and 14 are all assembled from the x2/x4/x8 chain
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

`ifndef INV_MIX_PARALLEL_EN
  logic [31:0] col_in;
  logic [31:0] col_out;

  always_comb begin
    col_in = in_reg[31:0];
    case (col_idx)
      2'd0:    col_in = in_reg[127:96];
      2'd1:    col_in = in_reg[95:64];
      2'd2:    col_in = in_reg[63:32];
      default: col_in = in_reg[31:0];
    endcase
  end

  assign col_out = inv_col(col_in);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      col_idx   <= '0;
      in_reg    <= '0;
      res_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_reg   <= state_i;
            col_idx  <= '0;
            fsm      <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
`ifdef INV_MIX_PARALLEL_EN
          res_reg   <= {inv_col(in_reg[127:96]), inv_col(in_reg[95:64]),
                        inv_col(in_reg[63:32]),  inv_col(in_reg[31:0])};
          fsm       <= DONE;
          out_valid <= 1'b1;
`else
          case (col_idx)
            2'd0:    res_reg[127:96] <= col_out;
            2'd1:    res_reg[95:64]  <= col_out;
            2'd2:    res_reg[63:32]  <= col_out;
            default: res_reg[31:0]   <= col_out;
          endcase
          if (col_idx == LAST_COL) begin
            col_idx   <= '0;
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            col_idx <= col_idx + CW'(1);
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = res_reg;

endmodule

// File: tb/tb_inv_mix_cols_dec.sv
// Bench for inv_mix_cols_dec: known vectors, handshake corner cases and a MixColumns round trip.
module tb_inv_mix_cols_dec;

`ifdef INV_MIX_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_o;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  inv_mix_cols_dec #(.NCOL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_i(state_i), .out_valid(out_valid), .out_ready(out_ready),
    .state_o(state_o), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // GF(2^8) product by shift-and-add, reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--)
      if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  // Circulant matrix product on every column; row r uses base[(j - r) mod 4] for byte j
  function automatic logic [127:0] mix(input logic [127:0] x, input bit inverse);
    logic [7:0] base [4];
    logic [127:0] y = '0;
    logic [7:0] acc;
    if (inverse) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(base[(j - r + 4) % 4], x[127 - 32*c - 8*j -: 8]);
        y[127 - 32*c - 8*r -: 8] = acc;
      end
    return y;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One full transfer; called between clock edges with the block in IDLE
  task automatic xfer(input string nm, input logic [127:0] s, input logic [127:0] exp);
    int n;
    chk({nm, " in_ready"}, 128'(in_ready), 128'(1));
    state_i = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 128'(n), 128'(LAT));
    chk({nm, " state_o"}, state_o, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " handoff"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  typedef struct {
    string        name;
    logic [127:0] s;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [4];

  localparam logic [127:0] VEC_A = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] EXP_A = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_B = {4{32'h4d7ebdf8}};
  localparam logic [127:0] EXP_B = {4{32'h2d26314c}};

  initial begin
    logic [127:0] x;
    logic [127:0] got [$];
    int acc_cyc [$];
    int hand_cyc [$];
    bit ok;
    int accepted;

    tbl[0] = '{"vec_a", VEC_A, EXP_A};
    tbl[1] = '{"vec_b", VEC_B, EXP_B};
    tbl[2] = '{"zeros", '0, '0};
    tbl[3] = '{"ones", {128{1'b1}}, {128{1'b1}}};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    state_i = '0;
    #12;
    chk("reset ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset state_o", state_o, '0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) xfer(tbl[i].name, tbl[i].s, tbl[i].exp);
    chk("model vec_a", mix(VEC_A, 1'b1), EXP_A);

    // backpressure: result must hold and a stray input must be ignored
    state_i = VEC_B;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT) begin @(posedge clk); #1; end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid && !in_ready && busy && state_o == EXP_B)) ok = 1'b0;
      if (i == 4) begin state_i = VEC_A; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp hold", 128'(ok), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    chk("bp state_o held", state_o, EXP_B);

    // back-to-back with out_ready tied high
    out_ready = 1'b1;
    accepted = 0;
    state_i = VEC_A;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_valid && in_ready) begin accepted++; acc_cyc.push_back(cyc); end
      if (out_valid && out_ready) begin got.push_back(state_o); hand_cyc.push_back(cyc); end
      @(posedge clk); #1;
      state_i = (accepted == 0) ? VEC_A : VEC_B;
      in_valid = (accepted < 2);
    end
    out_ready = 1'b0;
    chk("b2b count", 128'(got.size()), 128'(2));
    if (got.size() == 2 && acc_cyc.size() == 2) begin
      chk("b2b first", got[0], EXP_A);
      chk("b2b second", got[1], EXP_B);
      chk("b2b accept gap", 128'(acc_cyc[1] - hand_cyc[0]), 128'(1));
      chk("b2b period", 128'(hand_cyc[1] - hand_cyc[0]), 128'(LAT + 2));
    end

    // asynchronous reset two cycles into BUSY
    state_i = VEC_A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("midrst state_o", state_o, '0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid || busy) ok = 1'b0;
    end
    chk("midrst no out_valid", 128'(ok), 128'(1));
    xfer("after rst", VEC_B, EXP_B);

    // round trip through the encrypt-side mixer
    xfer("rt zeros", mix('0, 1'b0), '0);
    xfer("rt ones", mix({128{1'b1}}, 1'b0), {128{1'b1}});
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      xfer("round trip", mix(x, 1'b0), x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_mix_cols_dec.md
Name: inv_mix_cols_dec

Overview:
- Decrypt-side counterpart of the column mixer: applies AES InvMixColumns to a full 128-bit state.
- Iterative core: one shared column datapath processes one 32-bit column per clock, four clocks per state.
- Sits in the decryption round path between AddRoundKey and InvShiftRows/InvSubBytes.
- Valid/ready handshakes on both input and output sides.

Parameters:
- NCOL, 4, columns per state (fixed by AES; used only for counter sizing).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  upstream state available
- in_ready  output  1  block can accept a state
- state_i  input  128  input state; column c = state_i[127-32c -: 32], row 0 in the MSB byte of each column
- out_valid  output  1  result state held and valid
- out_ready  input  1  downstream accepts result
- state_o  output  128  InvMixColumns result, same packing as state_i
- busy  output  1  high in any non-IDLE state

Behaviour:
- Reset (async, rst=1): FSM=IDLE, col_idx=0, input and result registers=0, in_ready=1, out_valid=0, busy=0, state_o=0.
- Column function, bytes a0..a3 (row 0..3), GF(2^8) with poly 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplies are built from chained xtime (x2, x4, x8) plus XOR. No LUTs.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture state_i into the input register, set col_idx=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, compute column col_idx and write it into the matching 32-bit slice of the result register, then increment col_idx. When col_idx==3, write the last column, clear col_idx to 0 and go to DONE.
  - DONE: out_valid=1; state_o is stable. On out_ready=1, go to IDLE and drop out_valid on the same edge.
- Latency: accept edge to out_valid = 4 clocks. Throughput: one state per 6 clocks minimum (accept, 4 BUSY, handoff).
- in_ready is 0 in BUSY and DONE. The block ignores in_valid there and does not change state_i capture.
- state_o holds its last result after the DONE handoff and until the next DONE. It is qualified only by out_valid.
- out_ready asserted in IDLE/BUSY has no effect.
- Holding out_ready high continuously gives a DONE duration of exactly 1 cycle.
- rst asserted mid-BUSY or in DONE aborts immediately to the reset values. The partial result is discarded and no out_valid pulse occurs.
- col_idx is 2 bits; it never counts past 3.

Optional Feature:
- Macro INV_MIX_PARALLEL_EN.
- Defined:
  - Four column datapaths are instantiated.
  - The accept edge captures state_i, and the next edge writes all four result columns and enters DONE. Latency is 1 clock; BUSY is occupied for exactly one cycle.
  - col_idx is unused (held 0).
- Undefined: the iterative single-datapath behaviour above.
- Ports, handshake rules and reset behaviour are identical in both builds.

Test Plan:
- Single column vector: state_i=0x8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> after 4 clocks out_valid=1, state_o=0xdb135345_f20a225c_01010101_d4d4d4d5.
- Round-trip:
  - Feed random 128-bit states X through the encrypt-side column mixer, then into this block.
  - Result must equal X for 1000 states.
  - Include all-zero and all-0xff, which must map to themselves.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid stays 1, state_o stable, in_ready=0. Pulse in_valid with a different state -> it is ignored. Release out_ready -> IDLE next edge, in_ready=1.
- Back-to-back with out_ready tied 1: two states presented continuously -> second accepted 1 cycle after the first out_valid. Results are correct and in order: 0x2d26314c... column maps from 0x4d7ebdf8.
- Reset mid-operation: assert rst asynchronously 2 cycles into BUSY -> outputs drop immediately to reset values, no out_valid. A following accept produces the correct result.
- INV_MIX_PARALLEL_EN build: rerun the first vector -> out_valid one clock after accept, same state_o value.
